r4_butter_seq: RTL
==================

// Module: r4_butter_seq
// PURPOSE
//  Sequencer for the combinational radix-4 butterfly (R4_butter).
//  - Accepts one 4-point complex frame (xr0..3, xi0..3) over a valid/ready handshake and holds it stable on the butterfly inputs.
//  - Steps the butterfly output selects {c3,c2,c1} through X0..X3.
//  - Captures each Xr/Xi result and streams the four results out under valid/ready backpressure.
//  - Sits between the logic-analyser/Wishbone-facing input registers and the butterfly instance in user_project_wrapper.
// PARAMETERS
//  W       4   bit width of each real/imag sample and result
//  BF_LAT  1   cycles from a select change until Xr/Xi are sampled (settle time, >=1)
//  BITREV  0   1: emit results in order X0,X2,X1,X3; 0: natural order X0..X3
// PORTS
//  wb_clk_i   in   1    clock; all logic on rising edge
//  wb_rst_i   in   1    asynchronous, active-high reset
//  in_valid   in   1    frame valid
//  in_ready   out  1    frame accepted when in_valid & in_ready
//  in_xr      in   4*W  {xr3,xr2,xr1,xr0}
//  in_xi      in   4*W  {xi3,xi2,xi1,xi0}
//  bf_xr      out  4*W  held real samples to butterfly
//  bf_xi      out  4*W  held imag samples to butterfly
//  bf_c       out  3    {c3,c2,c1} output select to butterfly
//  bf_xro     in   W    butterfly real result
//  bf_xio     in   W    butterfly imag result
//  out_valid  out  1    result valid
//  out_ready  in   1    result consumed when out_valid & out_ready
//  out_xr     out  W    result real
//  out_xi     out  W    result imag
//  out_idx    out  2    bin index k of current result
//  out_last   out  1    high with the 4th result of a frame
//  busy       out  1    high in every state except IDLE
//  frame_cnt  out  8    completed frames, wraps 255->0
// BEHAVIOUR
//  Reset: all outputs low/zero; bf_c = SEL_X0; FSM = IDLE. Reset mid-frame discards the frame; nothing is emitted.
//  FSM states:
//   IDLE: in_ready=1. On accept, latch in_xr/in_xi into bf_xr/bf_xi; set step=0; bf_c=SEL(order(0)); -> SETTLE.
//   SETTLE: wait BF_LAT cycles (counter), then capture bf_xro/bf_xio into out_xr/out_xi; set out_idx=order(step); set out_last=(step==3); -> OUT.
//   OUT: out_valid=1; outputs held stable until out_ready.
//    - On handshake with step<3: step++; bf_c=SEL(order(step+1)); -> SETTLE.
//    - On handshake with step==3: frame_cnt++; -> IDLE.
//  order(s): natural s, or the bit-reversed sequence 0,2,1,3 when BITREV=1.
//  in_ready is 0 outside IDLE; no frame overlap.
//  bf_xr/bf_xi are held from accept until the next accept.
//  Latency (BF_LAT=1, out_ready tied 1):
//   - first out_valid is 2 cycles after accept;
//   - then one result every 2 cycles;
//   - next accept in the cycle after the last handshake.
//  out_valid never drops without a handshake. Output data never changes while out_valid=1 and out_ready=0.
//  Results are passed through unmodified (W bits; no rounding or scaling here; the butterfly owns the arithmetic).
// STRUCTURE
//  Package r4_pkg:
//   - W_DEF;
//   - select constants SEL_X0=3'b000, SEL_X1=3'b001, SEL_X2=3'b010, SEL_X3=3'b100 ({c3,c2,c1});
//   - FSM state enum {IDLE,SETTLE,OUT};
//   - function order(step,BITREV).
//  Single module, no sub-modules; the butterfly stays instantiated beside it in the wrapper.
// TESTING
//  1 Reset: assert wb_rst_i mid-SETTLE -> out_valid=0, busy=0, bf_c=000, frame_cnt=0, in_ready=1 the cycle after release.
//  2 Frame xr={4,3,2,1}, xi=0, out_ready=1, golden butterfly model -> 4 results, out_idx 0,1,2,3, out_last on 4th only, frame_cnt=1.
//  3 BITREV=1 -> out_idx sequence 0,2,1,3; bf_c sequence 000,010,001,100.
//  4 out_ready low 5 cycles on result 2 -> out_xr/out_xi/out_idx stable, bf_c unchanged, no extra results.
//  5 in_valid held high across 3 frames -> accepts only in IDLE; 12 results; frame_cnt=3.
//  6 BF_LAT=3 -> exactly 3 SETTLE cycles before each out_valid.
//  7 256 frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/r4_pkg.sv
// Shared definitions for the radix-4 butterfly sequencer.
// Provides the default sample width, the {c3,c2,c1} output-select codes
// understood by the combinational butterfly, the sequencer state encoding,
// and helpers mapping a result step to its bin index and select code.
package r4_pkg;

    localparam int W_DEF = 4;

    // One-hot-ish output selects for the butterfly, {c3,c2,c1}
    localparam logic [2:0] SEL_X0 = 3'b000;
    localparam logic [2:0] SEL_X1 = 3'b001;
    localparam logic [2:0] SEL_X2 = 3'b010;
    localparam logic [2:0] SEL_X3 = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } state_t;

    // Bin index emitted at a given step; bit-reversed order swaps the two bits
    function automatic logic [1:0] order(input logic [1:0] step, input logic bitrev);
        logic [1:0] idx;
        if (bitrev) begin
            idx = {step[0], step[1]};
        end else begin
            idx = step;
        end
        return idx;
    endfunction

    // Butterfly select code for a bin index
    function automatic logic [2:0] sel_of(input logic [1:0] idx);
        logic [2:0] sel;
        case (idx)
            2'd0:    sel = SEL_X0;
            2'd1:    sel = SEL_X1;
            2'd2:    sel = SEL_X2;
            2'd3:    sel = SEL_X3;
            default: sel = SEL_X0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/r4_butter_seq_if.sv
// Frame-in / result-out stream bundle for the butterfly sequencer.
// Signals:
//   in_valid/in_ready  frame handshake, in_xr/in_xi = {x3,x2,x1,x0}
//   out_valid/out_ready result handshake, out_xr/out_xi result,
//   out_idx bin index, out_last marks the 4th result of a frame.
// Modports: master = frame source / result sink, slave = sequencer.
interface r4_butter_seq_if #(
    parameter int W = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [4*W-1:0] in_xr;
    logic [4*W-1:0] in_xi;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_xr;
    logic [W-1:0]   out_xi;
    logic [1:0]     out_idx;
    logic           out_last;

    modport master (
        output in_valid, in_xr, in_xi, out_ready,
        input  in_ready, out_valid, out_xr, out_xi, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_xr, in_xi, out_ready,
        output in_ready, out_valid, out_xr, out_xi, out_idx, out_last
    );
endinterface

// File: rtl/r4_butter_seq.sv
// Sequencer for the combinational radix-4 butterfly.
// Accepts one 4-point complex frame, holds it on bf_xr/bf_xi, steps the
// butterfly select bf_c through the four bins, captures each result after
// BF_LAT settle cycles and streams it out under valid/ready backpressure.
// Ports:
//   wb_clk_i, wb_rst_i   clock, asynchronous active-high reset
//   bus                  frame-in / result-out stream (slave side)
//   bf_xr, bf_xi         held samples to the butterfly
//   bf_c                 {c3,c2,c1} output select to the butterfly
//   bf_xro, bf_xio       butterfly result for the current select
//   busy                 high outside IDLE
//   frame_cnt            completed frames, wraps 255->0
module r4_butter_seq
    import r4_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int BF_LAT = 1,
    parameter int BITREV = 0
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    r4_butter_seq_if.slave    bus,
    output logic [4*W-1:0]    bf_xr,
    output logic [4*W-1:0]    bf_xi,
    output logic [2:0]        bf_c,
    input  logic [W-1:0]      bf_xro,
    input  logic [W-1:0]      bf_xio,
    output logic              busy,
    output logic [7:0]        frame_cnt
);

    localparam int   CW    = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
    localparam logic REV   = (BITREV != 0);

    state_t         state_r;
    logic [1:0]     step_r;
    logic [CW-1:0]  cnt_r;
    logic [4*W-1:0] bf_xr_r;
    logic [4*W-1:0] bf_xi_r;
    logic [2:0]     bf_c_r;
    logic           in_ready_r;
    logic           out_valid_r;
    logic [W-1:0]   out_xr_r;
    logic [W-1:0]   out_xi_r;
    logic [1:0]     out_idx_r;
    logic           out_last_r;
    logic           busy_r;
    logic [7:0]     frame_cnt_r;

    logic           accept_s;
    logic           handshake_s;
    logic           settled_s;
    logic [1:0]     next_step_s;

    assign accept_s    = bus.in_valid & in_ready_r;
    assign handshake_s = out_valid_r & bus.out_ready;
    assign settled_s   = (cnt_r == CW'(BF_LAT - 1));
    assign next_step_s = step_r + 2'd1;

    // Sequencer FSM: every output is a register updated here
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r     <= IDLE;
            step_r      <= 2'd0;
            cnt_r       <= '0;
            bf_xr_r     <= '0;
            bf_xi_r     <= '0;
            bf_c_r      <= SEL_X0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_xr_r    <= '0;
            out_xi_r    <= '0;
            out_idx_r   <= 2'd0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            frame_cnt_r <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    in_ready_r <= 1'b1;
                    busy_r     <= 1'b0;
                    if (accept_s) begin
                        bf_xr_r    <= bus.in_xr;
                        bf_xi_r    <= bus.in_xi;
                        step_r     <= 2'd0;
                        cnt_r      <= '0;
                        bf_c_r     <= sel_of(order(2'd0, REV));
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settled_s) begin
                        out_xr_r    <= bf_xro;
                        out_xi_r    <= bf_xio;
                        out_idx_r   <= order(step_r, REV);
                        out_last_r  <= (step_r == 2'd3);
                        out_valid_r <= 1'b1;
                        state_r     <= OUT;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                OUT: begin
                    if (handshake_s) begin
                        out_valid_r <= 1'b0;
                        if (step_r == 2'd3) begin
                            // Ready in the very next cycle for back-to-back frames
                            frame_cnt_r <= frame_cnt_r + 8'd1;
                            in_ready_r  <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= IDLE;
                        end else begin
                            step_r  <= next_step_s;
                            bf_c_r  <= sel_of(order(next_step_s, REV));
                            cnt_r   <= '0;
                            state_r <= SETTLE;
                        end
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_xr    = out_xr_r;
    assign bus.out_xi    = out_xi_r;
    assign bus.out_idx   = out_idx_r;
    assign bus.out_last  = out_last_r;
    assign bf_xr         = bf_xr_r;
    assign bf_xi         = bf_xi_r;
    assign bf_c          = bf_c_r;
    assign busy          = busy_r;
    assign frame_cnt     = frame_cnt_r;

endmodule
